// File: rtl/inta_sequencer.sv
// 8259 interrupt-acknowledge sequencer: owns ISR and the rotating priority pointer,
// raises INT and runs the two-pulse INTA handshake with EOI/AEOI handling.
module inta_sequencer #(
    parameter int unsigned INTA_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] IRR,
    input  logic [4:0] ICW2_BASE,
    input  logic       AEOI,
    input  logic       ROTATE_EN,
    input  logic       EOI_STB,
    input  logic       SEOI_STB,
    input  logic [2:0] SEOI_LVL,
    input  logic       INTA_N,
    output logic       INT,
    output logic [7:0] IRR_CLR,
    output logic [7:0] ISR,
    output logic [7:0] VEC_DATA,
    output logic       VEC_OE,
    output logic [2:0] PRI_PTR,
    output logic       ACK_ERR
);

    localparam logic [7:0] LP_TIMEOUT = 8'(INTA_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK1 = 2'd1,
        S_GAP  = 2'd2,
        S_ACK2 = 2'd3
    } state_t;

    // Returns {found, rank} of the highest-priority set bit; level = ptr + 1 + rank.
    function automatic logic [3:0] f_rank(input logic [7:0] v, input logic [2:0] ptr);
        logic [3:0] res;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (v[3'(ptr + 3'd1 + 3'(k))]) res = {1'b1, 3'(k)};
        end
        return res;
    endfunction

    state_t     r_state, w_state_nxt;
    logic [7:0] r_isr, w_isr_nxt;
    logic [2:0] r_ptr, w_ptr_nxt;
    logic [2:0] r_lvl, w_lvl_nxt;
    logic       r_spur, w_spur_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_int, w_int_nxt;
    logic [7:0] r_irr_clr, w_irr_clr_nxt;
    logic [7:0] r_vec_data, w_vec_data_nxt;
    logic       r_vec_oe, w_vec_oe_nxt;
    logic       r_ack_err, w_ack_err_nxt;
    logic       r_inta_prev;

    logic [3:0] w_win, w_isr_hi;
    logic [2:0] w_win_lvl, w_isr_lvl, w_eoi_lvl;
    logic [7:0] w_isr_set, w_eoi_clr, w_aeoi_clr;
    logic       w_eoi_rot, w_aeoi_rot, w_fall;

    assign w_win     = f_rank(IRR, r_ptr);
    assign w_isr_hi  = f_rank(r_isr, r_ptr);
    assign w_win_lvl = 3'(r_ptr + 3'd1 + w_win[2:0]);
    assign w_isr_lvl = 3'(r_ptr + 3'd1 + w_isr_hi[2:0]);
    assign w_fall    = !INTA_N && r_inta_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_isr       <= 8'd0;
            r_ptr       <= 3'd7;
            r_lvl       <= 3'd0;
            r_spur      <= 1'b0;
            r_cnt       <= 8'd0;
            r_int       <= 1'b0;
            r_irr_clr   <= 8'd0;
            r_vec_data  <= 8'd0;
            r_vec_oe    <= 1'b0;
            r_ack_err   <= 1'b0;
            r_inta_prev <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_isr       <= w_isr_nxt;
            r_ptr       <= w_ptr_nxt;
            r_lvl       <= w_lvl_nxt;
            r_spur      <= w_spur_nxt;
            r_cnt       <= w_cnt_nxt;
            r_int       <= w_int_nxt;
            r_irr_clr   <= w_irr_clr_nxt;
            r_vec_data  <= w_vec_data_nxt;
            r_vec_oe    <= w_vec_oe_nxt;
            r_ack_err   <= w_ack_err_nxt;
            r_inta_prev <= INTA_N;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lvl_nxt      = r_lvl;
        w_spur_nxt     = r_spur;
        w_cnt_nxt      = r_cnt;
        w_irr_clr_nxt  = 8'd0;
        w_vec_data_nxt = r_vec_data;
        w_vec_oe_nxt   = r_vec_oe;
        w_ack_err_nxt  = 1'b0;
        w_isr_set      = 8'd0;
        w_aeoi_clr     = 8'd0;
        w_aeoi_rot     = 1'b0;
        w_eoi_clr      = 8'd0;
        w_eoi_rot      = 1'b0;
        w_eoi_lvl      = 3'd0;

        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_ACK1;
                    // A request withdrawn before the edge yields a spurious level-7 ack.
                    if (r_int && w_win[3]) begin
                        w_lvl_nxt     = w_win_lvl;
                        w_spur_nxt    = 1'b0;
                        w_isr_set     = 8'd1 << w_win_lvl;
                        w_irr_clr_nxt = 8'd1 << w_win_lvl;
                    end else begin
                        w_lvl_nxt  = 3'd7;
                        w_spur_nxt = 1'b1;
                    end
                end
            end
            S_ACK1: begin
                if (INTA_N) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_GAP: begin
                if (w_fall) begin
                    w_state_nxt    = S_ACK2;
                    w_vec_oe_nxt   = 1'b1;
                    w_vec_data_nxt = {ICW2_BASE, r_lvl};
                end else begin
                    w_cnt_nxt = 8'(r_cnt + 8'd1);
                    if (8'(r_cnt + 8'd1) == LP_TIMEOUT) begin
                        w_ack_err_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end
            end
            S_ACK2: begin
                if (INTA_N) begin
                    w_state_nxt  = S_IDLE;
                    w_vec_oe_nxt = 1'b0;
                    if (AEOI && !r_spur) begin
                        w_aeoi_clr = 8'd1 << r_lvl;
                        w_aeoi_rot = ROTATE_EN;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // EOIs are judged against the pre-set ISR; specific beats non-specific.
        if (SEOI_STB) begin
            w_eoi_clr = 8'd1 << SEOI_LVL;
            w_eoi_rot = ROTATE_EN;
            w_eoi_lvl = SEOI_LVL;
        end else if (EOI_STB && w_isr_hi[3]) begin
            w_eoi_clr = 8'd1 << w_isr_lvl;
            w_eoi_rot = ROTATE_EN;
            w_eoi_lvl = w_isr_lvl;
        end

        w_isr_nxt = (r_isr | w_isr_set) & ~w_eoi_clr & ~w_aeoi_clr;

        if (w_eoi_rot)       w_ptr_nxt = w_eoi_lvl;
        else if (w_aeoi_rot) w_ptr_nxt = r_lvl;
        else                 w_ptr_nxt = r_ptr;

        w_int_nxt = (w_state_nxt == S_IDLE) && w_win[3] &&
                    (!w_isr_hi[3] || (w_win[2:0] < w_isr_hi[2:0]));
    end

    assign INT      = r_int;
    assign IRR_CLR  = r_irr_clr;
    assign ISR      = r_isr;
    assign VEC_DATA = r_vec_data;
    assign VEC_OE   = r_vec_oe;
    assign PRI_PTR  = r_ptr;
    assign ACK_ERR  = r_ack_err;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed self-checking bench for inta_sequencer (built with INTA_TIMEOUT = 4).
module tb_inta_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] IRR;
    logic [4:0] ICW2_BASE;
    logic       AEOI, ROTATE_EN, EOI_STB, SEOI_STB;
    logic [2:0] SEOI_LVL;
    logic       INTA_N;
    logic       INT;
    logic [7:0] IRR_CLR, ISR, VEC_DATA;
    logic       VEC_OE;
    logic [2:0] PRI_PTR;
    logic       ACK_ERR;

    int checks = 0;
    int errors = 0;

    inta_sequencer #(.INTA_TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .IRR(IRR), .ICW2_BASE(ICW2_BASE), .AEOI(AEOI),
        .ROTATE_EN(ROTATE_EN), .EOI_STB(EOI_STB), .SEOI_STB(SEOI_STB),
        .SEOI_LVL(SEOI_LVL), .INTA_N(INTA_N), .INT(INT), .IRR_CLR(IRR_CLR),
        .ISR(ISR), .VEC_DATA(VEC_DATA), .VEC_OE(VEC_OE), .PRI_PTR(PRI_PTR),
        .ACK_ERR(ACK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full two-pulse acknowledge, one cycle low / one cycle high each.
    task automatic handshake();
        INTA_N = 1'b0; tick();
        INTA_N = 1'b1; tick();
        INTA_N = 1'b0; tick();
        INTA_N = 1'b1; tick();
    endtask

    initial begin
        RST = 1'b1; IRR = 8'h00; ICW2_BASE = 5'b01000; AEOI = 1'b0; ROTATE_EN = 1'b0;
        EOI_STB = 1'b0; SEOI_STB = 1'b0; SEOI_LVL = 3'd0; INTA_N = 1'b1;
        tick(2);
        RST = 1'b0;
        check("rst_int", 8'(INT), 8'h00);
        check("rst_isr", ISR, 8'h00);
        check("rst_ptr", 8'(PRI_PTR), 8'h07);
        check("rst_vec", VEC_DATA, 8'h00);
        check("rst_oe", 8'(VEC_OE), 8'h00);
        check("rst_clr", IRR_CLR, 8'h00);
        check("rst_err", 8'(ACK_ERR), 8'h00);

        // Basic acknowledge
        IRR = 8'h24; tick();
        check("basic_int", 8'(INT), 8'h01);
        INTA_N = 1'b0; tick();
        check("basic_clr", IRR_CLR, 8'h04);
        check("basic_isr", ISR, 8'h04);
        check("basic_int_drop", 8'(INT), 8'h00);
        IRR = 8'h20; tick();
        check("basic_clr_pulse", IRR_CLR, 8'h00);
        INTA_N = 1'b1; tick();
        INTA_N = 1'b0; tick();
        check("basic_vec", VEC_DATA, 8'h42);
        check("basic_oe", 8'(VEC_OE), 8'h01);
        tick();
        check("basic_oe_held", 8'(VEC_OE), 8'h01);
        INTA_N = 1'b1; tick();
        check("basic_oe_drop", 8'(VEC_OE), 8'h00);
        check("basic_isr_kept", ISR, 8'h04);
        tick();
        check("basic_lower_blocked", 8'(INT), 8'h00);
        EOI_STB = 1'b1; tick(); EOI_STB = 1'b0;
        check("basic_eoi", ISR, 8'h00);
        tick();
        check("basic_ir5_int", 8'(INT), 8'h01);
        IRR = 8'h00; tick(2);

        // Nesting
        IRR = 8'h08; tick();
        handshake();
        IRR = 8'h00;
        check("nest_isr08", ISR, 8'h08);
        IRR = 8'h20; tick(2);
        check("nest_ir5_blocked", 8'(INT), 8'h00);
        IRR = 8'h22; tick();
        check("nest_ir1_int", 8'(INT), 8'h01);
        handshake();
        IRR = 8'h00;
        check("nest_isr0a", ISR, 8'h0A);
        check("nest_vec", VEC_DATA, 8'h41);
        EOI_STB = 1'b1; tick(); EOI_STB = 1'b0;
        check("nest_eoi1", ISR, 8'h08);
        EOI_STB = 1'b1; tick(); EOI_STB = 1'b0;
        check("nest_eoi2", ISR, 8'h00);
        tick();

        // AEOI with rotation
        AEOI = 1'b1; ROTATE_EN = 1'b1;
        IRR = 8'h01; tick();
        handshake();
        check("aeoi_isr", ISR, 8'h00);
        check("aeoi_ptr", 8'(PRI_PTR), 8'h00);
        IRR = 8'h03; tick(2);
        handshake();
        check("aeoi_ir1_first", VEC_DATA, 8'h41);
        check("aeoi_ptr1", 8'(PRI_PTR), 8'h01);
        AEOI = 1'b0; ROTATE_EN = 1'b0; IRR = 8'h00;
        RST = 1'b1; tick(); RST = 1'b0;
        check("rst_ptr_again", 8'(PRI_PTR), 8'h07);

        // Spurious acknowledge
        IRR = 8'h10; tick();
        check("spur_int", 8'(INT), 8'h01);
        IRR = 8'h00; tick();
        check("spur_int_drop", 8'(INT), 8'h00);
        INTA_N = 1'b0; tick();
        check("spur_clr", IRR_CLR, 8'h00);
        check("spur_isr", ISR, 8'h00);
        INTA_N = 1'b1; tick();
        INTA_N = 1'b0; tick();
        check("spur_vec", VEC_DATA, 8'h47);
        INTA_N = 1'b1; tick();

        // Timeout
        IRR = 8'h04; tick();
        INTA_N = 1'b0; tick();
        IRR = 8'h00;
        INTA_N = 1'b1; tick();
        tick(3);
        check("to_not_yet", 8'(ACK_ERR), 8'h00);
        tick();
        check("to_err", 8'(ACK_ERR), 8'h01);
        check("to_isr_kept", ISR, 8'h04);
        IRR = 8'h02; tick();
        check("to_err_pulse", 8'(ACK_ERR), 8'h00);
        check("to_idle_int", 8'(INT), 8'h01);
        IRR = 8'h00; EOI_STB = 1'b1; tick(); EOI_STB = 1'b0;
        check("to_eoi", ISR, 8'h00);
        tick();

        // Reset during ACK2
        IRR = 8'h01; tick();
        INTA_N = 1'b0; tick();
        INTA_N = 1'b1; tick();
        INTA_N = 1'b0; tick();
        check("rst2_oe", 8'(VEC_OE), 8'h01);
        RST = 1'b1; tick();
        check("rst2_oe_off", 8'(VEC_OE), 8'h00);
        check("rst2_isr", ISR, 8'h00);
        RST = 1'b0; INTA_N = 1'b1; IRR = 8'h00; tick();

        // Simultaneous strobes
        IRR = 8'h40; tick();
        handshake();
        IRR = 8'h01; tick();
        handshake();
        IRR = 8'h00;
        check("sim_isr41", ISR, 8'h41);
        EOI_STB = 1'b1; SEOI_STB = 1'b1; SEOI_LVL = 3'd6; tick();
        EOI_STB = 1'b0; SEOI_STB = 1'b0;
        check("sim_seoi_wins", ISR, 8'h01);
        check("sim_ptr_norot", 8'(PRI_PTR), 8'h07);
        ROTATE_EN = 1'b1; SEOI_STB = 1'b1; SEOI_LVL = 3'd3; tick();
        SEOI_STB = 1'b0; ROTATE_EN = 1'b0;
        check("seoi_clear_bit_rot", 8'(PRI_PTR), 8'h03);
        check("seoi_clear_bit_isr", ISR, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

Synchronous interrupt-acknowledge sequencer for the 8259 PIC. It sits between the priority block's masked request register (IRR) and the CPU INTA/data-bus side. It owns the in-service register (ISR) and the rotating priority pointer, and raises INT to the CPU. It runs the two-pulse 8086-style INTA handshake: the first pulse freezes and moves the winning level from IRR to ISR, the second drives the vector. EOI handling, automatic EOI and priority rotation also live here.

## Interface
Parameters:
- INTA_TIMEOUT, 255: maximum cycles allowed between the end of the first INTA pulse and the start of the second; range 1–255.

Ports:
- CLK  in  1  sole clock; all state changes on its rising edge
- RST  in  1  reset, synchronous, active-high
- IRR  in  8  masked pending requests from the request register
- ICW2_BASE  in  5  vector base T7..T3
- AEOI  in  1  automatic-EOI mode
- ROTATE_EN  in  1  rotate priority on every EOI (automatic or commanded)
- EOI_STB  in  1  one-cycle non-specific EOI command
- SEOI_STB  in  1  one-cycle specific EOI command
- SEOI_LVL  in  3  level targeted by SEOI_STB
- INTA_N  in  1  CPU acknowledge, active-low, already synchronised to CLK
- INT  out  1  interrupt request to CPU
- IRR_CLR  out  8  one-cycle, one-hot clear pulse to the request register
- ISR  out  8  in-service register
- VEC_DATA  out  8  vector byte {ICW2_BASE, level}
- VEC_OE  out  1  VEC_DATA valid / bus drive enable
- PRI_PTR  out  3  lowest-priority level
- ACK_ERR  out  1  one-cycle pulse on handshake timeout

## Operation
- **Priority rank:** rank(i) = (i − PRI_PTR − 1) mod 8; rank 0 is highest. With PRI_PTR = 7, IR0 is highest.
- **Winner and INT:** the winner is the IRR bit with the lowest rank. In IDLE, INT = 1 iff a winner exists and its rank is below the rank of the highest-priority set ISR bit (or ISR = 0). INT is forced to 0 outside IDLE.
- **INTA edges:** a falling edge is a cycle where INTA_N samples 0 and the previous sample was 1.
- **States:** IDLE, ACK1, GAP, ACK2.
- **IDLE → ACK1** on an INTA falling edge:
  - Latch L = the current winner.
  - Set ISR[L] and pulse IRR_CLR[L].
  - If INT was 0 at that edge (request withdrawn), this is a spurious acknowledge: L = 7, ISR and IRR_CLR are untouched, and the spurious flag is set.
- **ACK1 → GAP** when INTA_N samples 1; the timeout counter is cleared.
- **GAP → ACK2** on an INTA falling edge: VEC_OE = 1, VEC_DATA = {ICW2_BASE, L}.
- **GAP → IDLE** when the counter reaches INTA_TIMEOUT: pulse ACK_ERR; ISR[L] stays set until software EOI.
- **ACK2 → IDLE** when INTA_N samples 1: VEC_OE = 0.
  - If AEOI = 1 and not spurious, clear ISR[L].
  - If additionally ROTATE_EN = 1, PRI_PTR ← L.
- **Non-specific EOI:** clears the lowest-rank set ISR bit; PRI_PTR ← that level if ROTATE_EN = 1. No effect if ISR = 0.
- **Specific EOI:** clears ISR[SEOI_LVL]; PRI_PTR ← SEOI_LVL if ROTATE_EN = 1, even if the bit was already clear.
- **Simultaneous strobes:** if EOI_STB and SEOI_STB arrive together, the specific EOI wins.
- **EOI in the ISR-set cycle:** an EOI in the same cycle as an ISR set is evaluated against the pre-set ISR, and both updates apply.
- **EOI timing:** EOIs are accepted in any state.
- **Rotation:** PRI_PTR changes only through EOI or AEOI rotation.

## Timing
- **Reset values:** INT = 0, IRR_CLR = 0, ISR = 0, VEC_DATA = 0, VEC_OE = 0, PRI_PTR = 7, ACK_ERR = 0; state IDLE, counter 0. Reset mid-handshake abandons it and applies these values at the next edge.
- **INT:** registered; it reflects IRR/ISR one cycle after they change and drops in the cycle after the first INTA edge is detected.
- **First acknowledge:** ISR[L] and IRR_CLR[L] become visible one cycle after first-edge detection. IRR_CLR is high for exactly one cycle.
- **Vector:** VEC_OE/VEC_DATA become valid one cycle after second-edge detection and stay stable until the cycle after INTA_N samples 1.
- **AEOI clear:** occurs in the same cycle VEC_OE drops.
- **Timeout counter:** 8-bit, increments every GAP cycle. ACK_ERR fires on the cycle it equals INTA_TIMEOUT; it does not wrap.
- **EOI strobes:** take effect on ISR/PRI_PTR one cycle after the strobe. INT re-evaluates on the following cycle.
- **Held INTA_N:** holding INTA_N low in ACK1 or ACK2 keeps the block in that state indefinitely.

## Test plan
- **Basic acknowledge:** RST, ICW2_BASE = 5'b01000, IRR = 8'h24 → INT = 1. On INTA #1: IRR_CLR = 8'h04, ISR = 8'h04. On INTA #2: VEC_DATA = 8'h42, VEC_OE for the pulse duration. Then EOI_STB → ISR = 0.
- **Nesting:** ISR = 8'h08 in service, raise IRR[5] → INT stays 0. Raise IRR[1] → INT = 1, second acknowledge gives ISR = 8'h0A.
- **AEOI with rotation:** AEOI = 1, ROTATE_EN = 1, IRR = 8'h01. After the handshake: ISR = 0, PRI_PTR = 0, and IR1 is now highest.
- **Spurious:** IRR pulses 8'h10 and drops before INTA #1 → ISR unchanged, IRR_CLR = 0, VEC_DATA = {base, 3'd7}.
- **Timeout:** INTA_TIMEOUT = 4, single INTA pulse only → ACK_ERR pulses 4 GAP cycles later, state returns to IDLE, ISR bit remains set.
- **Reset and simultaneous strobes:** assert RST during ACK2 → VEC_OE = 0 and ISR = 0 next cycle. Separately, EOI_STB and SEOI_STB together (SEOI_LVL = 6) with ISR = 8'h41 → ISR = 8'h01.
